// File: rtl/spi_reg_ctrl.sv
// spi_reg_ctrl: bridges an SPI slave byte stream onto a simple register bus.
// First byte after CS falls is a command: bit7=1 read, bit7=0 write, [6:0] start
// address; following bytes are write data (or dummy bytes for reads), address
// auto-increments modulo 128 after every access, completed or timed out.
// Ports: i_Clk/i_Rst clock and async active-high reset; i_SPI_CS_n raw chip select;
// i_RX_DV/i_RX_Byte received byte; o_TX_DV/o_TX_Byte next MISO byte load;
// o_Reg_Wr/o_Reg_Rd/o_Reg_Addr/o_Reg_WData/i_Reg_RData/i_Reg_Ack register bus;
// o_Busy not idle; o_Err_Cnt saturating timeout/overrun count.
module spi_reg_ctrl #(
  parameter logic [7:0] STATUS_BYTE = 8'hA5,
  parameter int         TIMEOUT     = 16
) (
  input  logic       i_Clk,
  input  logic       i_Rst,
  input  logic       i_SPI_CS_n,
  input  logic       i_RX_DV,
  input  logic [7:0] i_RX_Byte,
  output logic       o_TX_DV,
  output logic [7:0] o_TX_Byte,
  output logic       o_Reg_Wr,
  output logic       o_Reg_Rd,
  output logic [6:0] o_Reg_Addr,
  output logic [7:0] o_Reg_WData,
  input  logic [7:0] i_Reg_RData,
  input  logic       i_Reg_Ack,
  output logic       o_Busy,
  output logic [7:0] o_Err_Cnt
);
  typedef enum logic [2:0] {IDLE, CMD, WR_DATA, WR_BUS, RD_BUS, RD_DATA} state_t;
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);
  state_t     state_q, state_d;
  logic       cs_meta_q, cs_s_q, cs_prev_q;
  logic       tx_dv_q, tx_dv_d, wr_q, wr_d, rd_q, rd_d, err_inc;
  logic [7:0] tx_byte_q, tx_byte_d, wdata_q, wdata_d, err_q, err_d, tmo_q, tmo_d;
  logic [6:0] addr_q, addr_d;
  wire        cs_fall = cs_prev_q && !cs_s_q;
  wire        tmo_hit = tmo_q == TMO_LAST;
  always_ff @(posedge i_Clk or posedge i_Rst)
    if (i_Rst) begin
      state_q   <= IDLE;
      cs_meta_q <= 1'b1;
      cs_s_q    <= 1'b1;
      cs_prev_q <= 1'b1;
      tx_dv_q   <= 1'b0;
      tx_byte_q <= 8'h00;
      wr_q      <= 1'b0;
      rd_q      <= 1'b0;
      addr_q    <= 7'h00;
      wdata_q   <= 8'h00;
      err_q     <= 8'h00;
      tmo_q     <= 8'h00;
    end else begin
      state_q   <= state_d;
      cs_meta_q <= i_SPI_CS_n;
      cs_s_q    <= cs_meta_q;
      cs_prev_q <= cs_s_q;
      tx_dv_q   <= tx_dv_d;
      tx_byte_q <= tx_byte_d;
      wr_q      <= wr_d;
      rd_q      <= rd_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      err_q     <= err_d;
      tmo_q     <= tmo_d;
    end
  always_comb begin
    state_d   = state_q;
    tx_dv_d   = 1'b0;
    tx_byte_d = tx_byte_q;
    wr_d      = wr_q;
    rd_d      = rd_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    tmo_d     = tmo_q;
    err_inc   = 1'b0;
    // CS deselect aborts silently and outranks any ack or byte in the same cycle
    if (state_q != IDLE && cs_s_q) begin
      state_d = IDLE;
      wr_d    = 1'b0;
      rd_d    = 1'b0;
    end else
      case (state_q)
        IDLE: if (cs_fall) begin
          tx_dv_d   = 1'b1;
          tx_byte_d = STATUS_BYTE;
          state_d   = CMD;
        end
        CMD: if (i_RX_DV) begin
          addr_d  = i_RX_Byte[6:0];
          state_d = i_RX_Byte[7] ? RD_BUS : WR_DATA;
          rd_d    = i_RX_Byte[7];
          tmo_d   = 8'h00;
        end
        WR_DATA: if (i_RX_DV) begin
          wdata_d = i_RX_Byte;
          wr_d    = 1'b1;
          tmo_d   = 8'h00;
          state_d = WR_BUS;
        end
        WR_BUS: begin
          err_inc = i_RX_DV;
          if (i_Reg_Ack || tmo_hit) begin
            wr_d    = 1'b0;
            addr_d  = addr_q + 7'd1;
            state_d = WR_DATA;
            err_inc = i_RX_DV || !i_Reg_Ack;
          end else
            tmo_d = tmo_q + 8'd1;
        end
        RD_BUS: begin
          err_inc = i_RX_DV;
          if (i_Reg_Ack || tmo_hit) begin
            rd_d      = 1'b0;
            tx_dv_d   = 1'b1;
            tx_byte_d = i_Reg_Ack ? i_Reg_RData : 8'hFF;
            addr_d    = addr_q + 7'd1;
            state_d   = RD_DATA;
            err_inc   = i_RX_DV || !i_Reg_Ack;
          end else
            tmo_d = tmo_q + 8'd1;
        end
        RD_DATA: if (i_RX_DV) begin
          rd_d    = 1'b1;
          tmo_d   = 8'h00;
          state_d = RD_BUS;
        end
        default: state_d = IDLE;
      endcase
    err_d = (err_inc && err_q != 8'hFF) ? err_q + 8'd1 : err_q;
  end
  assign o_TX_DV     = tx_dv_q;
  assign o_TX_Byte   = tx_byte_q;
  assign o_Reg_Wr    = wr_q;
  assign o_Reg_Rd    = rd_q;
  assign o_Reg_Addr  = addr_q;
  assign o_Reg_WData = wdata_q;
  assign o_Busy      = state_q != IDLE;
  assign o_Err_Cnt   = err_q;
endmodule

// File: tb/tb_spi_reg_ctrl.sv
// tb_spi_reg_ctrl: scoreboard bench for spi_reg_ctrl with an auto/manual-ack register responder.
module tb_spi_reg_ctrl;
  logic       i_Clk = 1'b0, i_Rst = 1'b1, i_SPI_CS_n = 1'b1, i_RX_DV = 1'b0, i_Reg_Ack = 1'b0;
  logic [7:0] i_RX_Byte = 8'h00, i_Reg_RData = 8'h00;
  logic       o_TX_DV, o_Reg_Wr, o_Reg_Rd, o_Busy;
  logic [7:0] o_TX_Byte, o_Reg_WData, o_Err_Cnt;
  logic [6:0] o_Reg_Addr;
  int         n_tests = 0, n_fail = 0, wr_hi = 0, ack_lat = 1;
  logic       auto_ack = 1'b1, man_ack = 1'b0, both_seen = 1'b0;
  logic [7:0] next_rdata = 8'h00;
  logic [7:0]  tx_exp[$], tx_got[$];
  logic [14:0] wr_exp[$], wr_got[$];
  logic [6:0]  rd_exp[$], rd_got[$];

  spi_reg_ctrl dut (
    .i_Clk(i_Clk), .i_Rst(i_Rst), .i_SPI_CS_n(i_SPI_CS_n), .i_RX_DV(i_RX_DV), .i_RX_Byte(i_RX_Byte),
    .o_TX_DV(o_TX_DV), .o_TX_Byte(o_TX_Byte), .o_Reg_Wr(o_Reg_Wr), .o_Reg_Rd(o_Reg_Rd),
    .o_Reg_Addr(o_Reg_Addr), .o_Reg_WData(o_Reg_WData), .i_Reg_RData(i_Reg_RData),
    .i_Reg_Ack(i_Reg_Ack), .o_Busy(o_Busy), .o_Err_Cnt(o_Err_Cnt)
  );

  always #5 i_Clk = ~i_Clk;

  always @(negedge i_Clk) begin
    if (o_TX_DV) tx_got.push_back(o_TX_Byte);
    if (o_Reg_Wr) wr_hi++;
    if (o_Reg_Wr && o_Reg_Rd) both_seen = 1'b1;
  end

  initial begin
    int age;
    age = 0;
    forever begin
      @(negedge i_Clk);
      if (!auto_ack) begin
        i_Reg_Ack = man_ack;
        age = 0;
      end else if ((o_Reg_Wr || o_Reg_Rd) && !i_Reg_Ack && age == ack_lat) begin
        i_Reg_Ack = 1'b1;
        i_Reg_RData = next_rdata;
        if (o_Reg_Wr) wr_got.push_back({o_Reg_Addr, o_Reg_WData});
        else rd_got.push_back(o_Reg_Addr);
        age = 0;
      end else begin
        i_Reg_Ack = 1'b0;
        age = (o_Reg_Wr || o_Reg_Rd) ? age + 1 : 0;
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic do_reset();
    i_Rst = 1'b1; i_SPI_CS_n = 1'b1; i_RX_DV = 1'b0; auto_ack = 1'b1; man_ack = 1'b0; ack_lat = 1;
    repeat (3) @(posedge i_Clk);
    #1 i_Rst = 1'b0;
    repeat (2) @(posedge i_Clk);
  endtask

  task automatic cs_low();
    @(posedge i_Clk); #1 i_SPI_CS_n = 1'b0;
    repeat (4) @(posedge i_Clk);
  endtask

  task automatic cs_high();
    @(posedge i_Clk); #1 i_SPI_CS_n = 1'b1;
    repeat (5) @(posedge i_Clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    @(posedge i_Clk); #1 i_RX_DV = 1'b1; i_RX_Byte = b;
    @(posedge i_Clk); #1 i_RX_DV = 1'b0;
    repeat (gap) @(posedge i_Clk);
  endtask

  task automatic test_reset();
    i_Rst = 1'b1;
    repeat (2) @(posedge i_Clk);
    #1;
    n_tests++; if (o_TX_DV !== 1'b0 || o_TX_Byte !== 8'h00) begin n_fail++; $display("FAIL reset_tx got dv=%b byte=%h exp 0/00", o_TX_DV, o_TX_Byte); end
    n_tests++; if (o_Reg_Wr !== 1'b0 || o_Reg_Rd !== 1'b0) begin n_fail++; $display("FAIL reset_req got wr=%b rd=%b exp 0/0", o_Reg_Wr, o_Reg_Rd); end
    n_tests++; if (o_Reg_Addr !== 7'h00 || o_Reg_WData !== 8'h00) begin n_fail++; $display("FAIL reset_addr got %h/%h exp 00/00", o_Reg_Addr, o_Reg_WData); end
    n_tests++; if (o_Busy !== 1'b0 || o_Err_Cnt !== 8'h00) begin n_fail++; $display("FAIL reset_busy_err got %b/%h exp 0/00", o_Busy, o_Err_Cnt); end
    do_reset();
  endtask

  task automatic test_write();
    int t0, w0;
    logic [7:0] e8;
    logic [14:0] e15;
    do_reset();
    t0 = tx_got.size(); w0 = wr_got.size();
    cs_low(); tx_exp.push_back(8'hA5);
    send_byte(8'h05, 6);
    send_byte(8'h11, 6); wr_exp.push_back({7'h05, 8'h11});
    send_byte(8'h22, 6); wr_exp.push_back({7'h06, 8'h22});
    #1;
    n_tests++; if (o_Reg_Addr !== 7'h07 || o_Err_Cnt !== 8'h00) begin n_fail++; $display("FAIL write_addr_err got %h/%h exp 07/00", o_Reg_Addr, o_Err_Cnt); end
    cs_high();
    #1;
    n_tests++; if (o_Busy !== 1'b0) begin n_fail++; $display("FAIL write_idle got busy=%b exp 0", o_Busy); end
    ack_lat = 0;
    cs_low(); tx_exp.push_back(8'hA5);
    send_byte(8'h10, 6);
    send_byte(8'h99, 6); wr_exp.push_back({7'h10, 8'h99});
    cs_high();
    n_tests++; if (tx_got.size() - t0 != tx_exp.size()) begin n_fail++; $display("FAIL write_tx_count got %0d exp %0d", tx_got.size() - t0, tx_exp.size()); end
    while (tx_exp.size() > 0) begin
      e8 = tx_exp.pop_front();
      n_tests++; if (t0 >= tx_got.size() || tx_got[t0] !== e8) begin n_fail++; $display("FAIL write_tx got %h exp %h", (t0 < tx_got.size()) ? tx_got[t0] : 8'hxx, e8); end
      t0++;
    end
    n_tests++; if (wr_got.size() - w0 != wr_exp.size()) begin n_fail++; $display("FAIL write_count got %0d exp %0d", wr_got.size() - w0, wr_exp.size()); end
    while (wr_exp.size() > 0) begin
      e15 = wr_exp.pop_front();
      n_tests++; if (w0 >= wr_got.size() || wr_got[w0] !== e15) begin n_fail++; $display("FAIL write_bus got %h exp %h", (w0 < wr_got.size()) ? wr_got[w0] : 15'hxxxx, e15); end
      w0++;
    end
  endtask

  task automatic test_read();
    int t0, r0;
    logic [7:0] e8;
    logic [6:0] e7;
    do_reset();
    t0 = tx_got.size(); r0 = rd_got.size();
    next_rdata = 8'h3C;
    cs_low(); tx_exp.push_back(8'hA5);
    send_byte(8'hFF, 6); rd_exp.push_back(7'h7F); tx_exp.push_back(8'h3C);
    next_rdata = 8'h4D;
    send_byte(8'h00, 6); rd_exp.push_back(7'h00); tx_exp.push_back(8'h4D);
    #1;
    n_tests++; if (o_Reg_Addr !== 7'h01 || o_Err_Cnt !== 8'h00 || o_Reg_Rd !== 1'b0) begin n_fail++; $display("FAIL read_state got addr=%h err=%h rd=%b exp 01/00/0", o_Reg_Addr, o_Err_Cnt, o_Reg_Rd); end
    cs_high();
    n_tests++; if (tx_got.size() - t0 != tx_exp.size()) begin n_fail++; $display("FAIL read_tx_count got %0d exp %0d", tx_got.size() - t0, tx_exp.size()); end
    while (tx_exp.size() > 0) begin
      e8 = tx_exp.pop_front();
      n_tests++; if (t0 >= tx_got.size() || tx_got[t0] !== e8) begin n_fail++; $display("FAIL read_tx got %h exp %h", (t0 < tx_got.size()) ? tx_got[t0] : 8'hxx, e8); end
      t0++;
    end
    n_tests++; if (rd_got.size() - r0 != rd_exp.size()) begin n_fail++; $display("FAIL read_count got %0d exp %0d", rd_got.size() - r0, rd_exp.size()); end
    while (rd_exp.size() > 0) begin
      e7 = rd_exp.pop_front();
      n_tests++; if (r0 >= rd_got.size() || rd_got[r0] !== e7) begin n_fail++; $display("FAIL read_addr got %h exp %h", (r0 < rd_got.size()) ? rd_got[r0] : 7'hxx, e7); end
      r0++;
    end
  endtask

  task automatic test_wr_timeout();
    int h0, w0;
    logic [14:0] e15;
    do_reset();
    auto_ack = 1'b0;
    w0 = wr_got.size();
    cs_low();
    send_byte(8'h20, 0);
    h0 = wr_hi;
    send_byte(8'h55, 20);
    #1;
    n_tests++; if (wr_hi - h0 != 16) begin n_fail++; $display("FAIL wr_timeout_len got %0d exp 16", wr_hi - h0); end
    n_tests++; if (o_Reg_Wr !== 1'b0 || o_Err_Cnt !== 8'h01 || o_Reg_Addr !== 7'h21) begin n_fail++; $display("FAIL wr_timeout_state got wr=%b err=%h addr=%h exp 0/01/21", o_Reg_Wr, o_Err_Cnt, o_Reg_Addr); end
    auto_ack = 1'b1; ack_lat = 1;
    send_byte(8'h66, 6); wr_exp.push_back({7'h21, 8'h66});
    cs_high();
    n_tests++; if (wr_got.size() - w0 != wr_exp.size()) begin n_fail++; $display("FAIL wr_timeout_count got %0d exp %0d", wr_got.size() - w0, wr_exp.size()); end
    while (wr_exp.size() > 0) begin
      e15 = wr_exp.pop_front();
      n_tests++; if (w0 >= wr_got.size() || wr_got[w0] !== e15) begin n_fail++; $display("FAIL wr_timeout_next got %h exp %h", (w0 < wr_got.size()) ? wr_got[w0] : 15'hxxxx, e15); end
      w0++;
    end
  endtask

  task automatic test_rd_timeout();
    int t0;
    logic [7:0] e8;
    do_reset();
    auto_ack = 1'b0;
    t0 = tx_got.size();
    cs_low(); tx_exp.push_back(8'hA5);
    send_byte(8'h83, 20); tx_exp.push_back(8'hFF);
    #1;
    n_tests++; if (o_Reg_Rd !== 1'b0 || o_Err_Cnt !== 8'h01 || o_Reg_Addr !== 7'h04) begin n_fail++; $display("FAIL rd_timeout_state got rd=%b err=%h addr=%h exp 0/01/04", o_Reg_Rd, o_Err_Cnt, o_Reg_Addr); end
    cs_high();
    n_tests++; if (tx_got.size() - t0 != tx_exp.size()) begin n_fail++; $display("FAIL rd_timeout_tx_count got %0d exp %0d", tx_got.size() - t0, tx_exp.size()); end
    while (tx_exp.size() > 0) begin
      e8 = tx_exp.pop_front();
      n_tests++; if (t0 >= tx_got.size() || tx_got[t0] !== e8) begin n_fail++; $display("FAIL rd_timeout_tx got %h exp %h", (t0 < tx_got.size()) ? tx_got[t0] : 8'hxx, e8); end
      t0++;
    end
  endtask

  task automatic test_cs_abort();
    int t0;
    do_reset();
    auto_ack = 1'b0;
    t0 = tx_got.size();
    cs_low();
    send_byte(8'h10, 0);
    send_byte(8'h77, 2);
    #1;
    n_tests++; if (o_Reg_Wr !== 1'b1) begin n_fail++; $display("FAIL abort_pre got wr=%b exp 1", o_Reg_Wr); end
    @(posedge i_Clk); #1 i_SPI_CS_n = 1'b1;
    @(posedge i_Clk);
    @(posedge i_Clk); #1 man_ack = 1'b1;
    @(posedge i_Clk); #1 man_ack = 1'b0;
    n_tests++; if (o_Reg_Wr !== 1'b0 || o_Busy !== 1'b0) begin n_fail++; $display("FAIL abort_state got wr=%b busy=%b exp 0/0", o_Reg_Wr, o_Busy); end
    n_tests++; if (o_Reg_Addr !== 7'h10 || o_Err_Cnt !== 8'h00) begin n_fail++; $display("FAIL abort_addr got addr=%h err=%h exp 10/00", o_Reg_Addr, o_Err_Cnt); end
    repeat (4) @(posedge i_Clk);
    n_tests++; if (tx_got.size() - t0 != 1) begin n_fail++; $display("FAIL abort_tx_count got %0d exp 1", tx_got.size() - t0); end
  endtask

  task automatic test_overrun();
    int w0;
    do_reset();
    auto_ack = 1'b0;
    w0 = wr_got.size();
    cs_low();
    send_byte(8'h30, 0);
    send_byte(8'hAA, 1);
    send_byte(8'hBB, 2);
    #1;
    n_tests++; if (o_Err_Cnt !== 8'h01 || o_Reg_WData !== 8'hAA || o_Reg_Wr !== 1'b1) begin n_fail++; $display("FAIL overrun_state got err=%h wdata=%h wr=%b exp 01/AA/1", o_Err_Cnt, o_Reg_WData, o_Reg_Wr); end
    ack_lat = 0; auto_ack = 1'b1;
    repeat (3) @(posedge i_Clk);
    #1;
    n_tests++; if (wr_got.size() - w0 != 1 || wr_got[w0] !== {7'h30, 8'hAA}) begin n_fail++; $display("FAIL overrun_write got n=%0d last=%h exp 1/30AA", wr_got.size() - w0, wr_got[wr_got.size() - 1]); end
    auto_ack = 1'b0;
    @(posedge i_Clk); #1 i_RX_DV = 1'b1; i_RX_Byte = 8'hC0;
    repeat (17) @(posedge i_Clk);
    #1 i_RX_DV = 1'b0;
    n_tests++; if (o_Err_Cnt !== 8'd17 || o_Reg_Wr !== 1'b0 || o_Reg_Addr !== 7'h32) begin n_fail++; $display("FAIL overrun_timeout got err=%0d wr=%b addr=%h exp 17/0/32", o_Err_Cnt, o_Reg_Wr, o_Reg_Addr); end
    cs_high();
  endtask

  task automatic test_saturate();
    do_reset();
    auto_ack = 1'b0;
    cs_low();
    send_byte(8'h40, 0);
    @(posedge i_Clk); #1 i_RX_DV = 1'b1; i_RX_Byte = 8'h01;
    repeat (400) @(posedge i_Clk);
    #1 i_RX_DV = 1'b0;
    n_tests++; if (o_Err_Cnt !== 8'hFF) begin n_fail++; $display("FAIL err_saturate got %h exp FF", o_Err_Cnt); end
    cs_high();
  endtask

  task automatic test_rst_mid_read();
    do_reset();
    auto_ack = 1'b0;
    cs_low();
    send_byte(8'h85, 2);
    #1;
    n_tests++; if (o_Reg_Rd !== 1'b1 || o_TX_Byte !== 8'hA5) begin n_fail++; $display("FAIL rst_pre got rd=%b tx=%h exp 1/A5", o_Reg_Rd, o_TX_Byte); end
    #2 i_Rst = 1'b1;
    #1;
    n_tests++; if (o_Reg_Rd !== 1'b0 || o_Reg_Wr !== 1'b0 || o_Busy !== 1'b0) begin n_fail++; $display("FAIL rst_async_req got rd=%b wr=%b busy=%b exp 0/0/0", o_Reg_Rd, o_Reg_Wr, o_Busy); end
    n_tests++; if (o_Reg_Addr !== 7'h00 || o_TX_Byte !== 8'h00 || o_TX_DV !== 1'b0 || o_Err_Cnt !== 8'h00 || o_Reg_WData !== 8'h00) begin n_fail++; $display("FAIL rst_async_regs got addr=%h tx=%h dv=%b err=%h wd=%h exp all 0", o_Reg_Addr, o_TX_Byte, o_TX_DV, o_Err_Cnt, o_Reg_WData); end
    do_reset();
  endtask

  task automatic test_mutex();
    n_tests++; if (both_seen !== 1'b0) begin n_fail++; $display("FAIL wr_rd_mutex got both_seen=%b exp 0", both_seen); end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_wr_timeout();
    test_rd_timeout();
    test_cs_abort();
    test_overrun();
    test_saturate();
    test_rst_mid_read();
    test_mutex();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/spi_reg_ctrl.md
SPI_REG_CTRL -- requirements
Module: spi_reg_ctrl

Interface
REQ-001 Parameter STATUS_BYTE, default 8'hA5, status byte loaded for MISO at start of every transaction.
REQ-002 Parameter TIMEOUT, default 16, cycles a register access waits for ack before abort; legal range 2..255.
REQ-003 Reset is asynchronous and active-high; the block has one clock.
REQ-004 i_Clk  input  1  system clock; all logic on rising edge.
REQ-005 i_Rst  input  1  asynchronous active-high reset.
REQ-006 i_SPI_CS_n  input  1  raw SPI chip select, active low, asynchronous to i_Clk.
REQ-007 i_RX_DV  input  1  one-cycle pulse, received SPI byte valid.
REQ-008 i_RX_Byte  input  8  received SPI byte, valid with i_RX_DV.
REQ-009 o_TX_DV  output  1  one-cycle pulse, loads o_TX_Byte into the SPI slave.
REQ-010 o_TX_Byte  output  8  byte for next MISO shift.
REQ-011 o_Reg_Wr  output  1  register write request, level, held until ack or timeout.
REQ-012 o_Reg_Rd  output  1  register read request, level, held until ack or timeout.
REQ-013 o_Reg_Addr  output  7  register address.
REQ-014 o_Reg_WData  output  8  register write data.
REQ-015 i_Reg_RData  input  8  register read data, valid with i_Reg_Ack during read.
REQ-016 i_Reg_Ack  input  1  one-cycle access completion pulse.
REQ-017 o_Busy  output  1  high whenever state is not IDLE.
REQ-018 o_Err_Cnt  output  8  saturating count of timeouts and overruns.

Function
REQ-019 i_SPI_CS_n SHALL pass a 2-flop synchronizer (reset value 1); cs_s denotes the synchronized level.
REQ-020 States SHALL be IDLE, CMD, WR_DATA, WR_BUS, RD_BUS, RD_DATA.
REQ-021 IDLE: on cs_s 1->0, pulse o_TX_DV with o_TX_Byte=STATUS_BYTE, go CMD.
REQ-022 CMD: on i_RX_DV, o_Reg_Addr<=i_RX_Byte[6:0]; bit7=1 -> RD_BUS, bit7=0 -> WR_DATA.
REQ-023 WR_DATA: on i_RX_DV, o_Reg_WData<=i_RX_Byte, o_Reg_Wr<=1, go WR_BUS.
REQ-024 WR_BUS: on i_Reg_Ack, o_Reg_Wr<=0, address increments, go WR_DATA.
REQ-025 RD_BUS: o_Reg_Rd<=1 on entry; on i_Reg_Ack, o_Reg_Rd<=0, pulse o_TX_DV with i_Reg_RData, address increments, go RD_DATA.
REQ-026 RD_DATA: on i_RX_DV (dummy byte, content ignored) go RD_BUS.
REQ-027 Request-to-ack latency is unbounded up to TIMEOUT; ack in the first request cycle SHALL be accepted.
REQ-028 Timeout: a 8-bit counter, cleared on request assertion, counts request cycles; at TIMEOUT without ack the request drops, o_Err_Cnt increments, address still increments; a read additionally pulses o_TX_DV with 8'hFF.
REQ-029 Address increment is modulo 128 (7'h7F -> 7'h00).
REQ-030 Overrun: i_RX_DV in WR_BUS or RD_BUS SHALL drop that byte and increment o_Err_Cnt; the access continues.
REQ-031 i_Reg_Ack outside WR_BUS/RD_BUS SHALL be ignored.
REQ-032 cs_s high in any non-IDLE state SHALL, next cycle, clear o_Reg_Wr/o_Reg_Rd, go IDLE, no increment, no o_TX_DV; takes priority over simultaneous ack or i_RX_DV.
REQ-033 o_Err_Cnt saturates at 8'hFF; timeout and overrun in one cycle count once.
REQ-034 o_Reg_Wr and o_Reg_Rd SHALL never be high together.

Reset
REQ-035 On i_Rst: state IDLE, o_TX_DV=0, o_TX_Byte=8'h00, o_Reg_Wr=0, o_Reg_Rd=0, o_Reg_Addr=0, o_Reg_WData=0, o_Busy=0, o_Err_Cnt=0, synchronizer=1, timeout counter=0.
REQ-036 Reset asserted mid-access SHALL drop requests immediately (asynchronously).

Verification
REQ-037 CS low, bytes 8'h05,8'h11,8'h22, ack 1 cycle after request -> writes addr 5=8'h11, addr 6=8'h22; TX loads 8'hA5 only.
REQ-038 CS low, cmd 8'hFF, RData 8'h3C then 8'h4D, one dummy byte -> TX sequence 8'hA5,8'h3C,8'h4D; read addresses 7'h7F then 7'h00.
REQ-039 Write, no ack -> o_Reg_Wr high exactly TIMEOUT cycles, then low; o_Err_Cnt=1; next byte writes addr+1.
REQ-040 Read, no ack -> o_TX_Byte=8'hFF with o_TX_DV pulse; o_Err_Cnt=1.
REQ-041 CS rises while o_Reg_Wr high, ack same cycle -> o_Reg_Wr low, IDLE, o_Busy=0, no increment.
REQ-042 i_RX_DV during WR_BUS -> byte not written, o_Err_Cnt +1; i_Rst mid-RD_BUS -> all outputs at reset values.
